icarus_work_sender: RTL and testbench

Controller-side endpoint of the host↔miner serial link: the transmitter for work packets and the receiver for golden-nonce replies. It serialises one 64-byte Icarus work packet ({midstate, data2}) onto a UART TX line. It then listens on the UART RX line for 4-byte nonce replies until a timeout expires. It drives a miner board's RxD/TxD pair from a test or controller FPGA on one clock.

---
 rtl/icarus_work_sender.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_icarus_work_sender.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/icarus_work_sender.sv
// icarus_work_sender: sends one 64-byte Icarus work packet over a UART TX line,
// then collects 4-byte golden-nonce replies on the UART RX line until a reply
// window expires. One clock, synchronous active-low reset.
module icarus_work_sender #(
  parameter int CLOCK          = 25000000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 25000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [255:0] midstate,
  input  logic [255:0] data2,
  input  logic         start,
  output logic         tx,
  input  logic         rx,
  output logic         busy,
  output logic [31:0]  nonce,
  output logic         nonce_valid,
  output logic         done
);

  localparam int DIV  = CLOCK / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF - 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Controller state and transmitter
  state_t         state_q,   state_d;
  logic [511:0]   shift_q,   shift_d;
  logic [5:0]     tx_byte_q, tx_byte_d;
  logic [3:0]     tx_bit_q,  tx_bit_d;
  logic [CW-1:0]  tx_cnt_q,  tx_cnt_d;
  logic           tx_q,      tx_d;
  logic           busy_q,    busy_d;
  logic [TW-1:0]  timer_q,   timer_d;

  // Nonce assembly; only the three older bytes need storing, the fourth
  // arrives on the same cycle the word is published
  logic [1:0]     rx_count_q, rx_count_d;
  logic [23:0]    asm_q,      asm_d;
  logic [31:0]    nonce_q,    nonce_d;
  logic           nonce_valid_q, nonce_valid_d;
  logic           done_q,     done_d;

  // Receiver
  logic           rx_s1_q, rx_s1_d;
  logic           rx_s2_q, rx_s2_d;
  logic           rx_s3_q, rx_s3_d;
  rx_state_t      rx_state_q, rx_state_d;
  logic [CW-1:0]  rx_cnt_q,   rx_cnt_d;
  logic [2:0]     rx_bit_q,   rx_bit_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic [7:0]     rx_byte_q,  rx_byte_d;
  logic           rx_good_q,  rx_good_d;
  logic           rx_ferr_q,  rx_ferr_d;

  logic [7:0]     cur_byte;
  logic           accept;

  assign cur_byte = shift_q[511:504];
  assign accept   = start && (state_q != SEND);

  // Next-state logic for the controller, the transmitter and the receiver
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    tx_byte_d     = tx_byte_q;
    tx_bit_d      = tx_bit_q;
    tx_cnt_d      = tx_cnt_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    timer_d       = timer_q;
    rx_count_d    = rx_count_q;
    asm_d         = asm_q;
    nonce_d       = nonce_q;
    nonce_valid_d = 1'b0;
    done_d        = 1'b0;

    rx_s1_d       = rx;
    rx_s2_d       = rx_s1_q;
    rx_s3_d       = rx_s2_q;
    rx_state_d    = rx_state_q;
    rx_cnt_d      = rx_cnt_q;
    rx_bit_d      = rx_bit_q;
    rx_shift_d    = rx_shift_q;
    rx_byte_d     = rx_byte_q;
    rx_good_d     = 1'b0;
    rx_ferr_d     = 1'b0;

    // Receiver: hunt for a falling edge, confirm the start bit at half a bit,
    // then sample each data bit and the stop bit one bit period apart
    case (rx_state_q)
      RX_HUNT: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            rx_bit_d   = '0;
          end else begin
            rx_state_d = RX_HUNT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_HUNT;
          if (rx_s2_q) begin
            rx_good_d = 1'b1;
            rx_byte_d = rx_shift_q;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CW'(1);
        end
      end
      default: rx_state_d = RX_HUNT;
    endcase

    // Controller: frame bytes MSB byte first in SEND, gather nonces in WAIT
    case (state_q)
      IDLE: begin
      end
      SEND: begin
        if (tx_cnt_q == DIV_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 4'd9) begin
            if (tx_byte_q == 6'd63) begin
              state_d    = WAIT;
              tx_d       = 1'b1;
              timer_d    = TIMER_LOAD;
              rx_count_d = '0;
            end else begin
              tx_byte_d = tx_byte_q + 6'd1;
              tx_bit_d  = '0;
              tx_d      = 1'b0;
              shift_d   = {shift_q[503:0], 8'h00};
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : cur_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (!start) begin
          if (timer_q <= TW'(1)) begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
            rx_count_d = '0;
          end else begin
            timer_d = timer_q - TW'(1);
            if (rx_ferr_q) begin
              rx_count_d = '0;
            end else if (rx_good_q) begin
              asm_d = {asm_q[15:0], rx_byte_q};
              if (rx_count_q == 2'd3) begin
                nonce_d       = {asm_q, rx_byte_q};
                nonce_valid_d = 1'b1;
                rx_count_d    = '0;
              end else begin
                rx_count_d = rx_count_q + 2'd1;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A new start in IDLE or WAIT latches work and begins the start bit of byte 0
    if (accept) begin
      state_d   = SEND;
      shift_d   = {midstate, data2};
      tx_byte_d = '0;
      tx_bit_d  = '0;
      tx_cnt_d  = '0;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
    end
  end

  // Register update with synchronous reset to an idle line and empty counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      tx_byte_q     <= '0;
      tx_bit_q      <= '0;
      tx_cnt_q      <= '0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      timer_q       <= '0;
      rx_count_q    <= '0;
      asm_q         <= '0;
      nonce_q       <= '0;
      nonce_valid_q <= 1'b0;
      done_q        <= 1'b0;
      rx_s1_q       <= 1'b1;
      rx_s2_q       <= 1'b1;
      rx_s3_q       <= 1'b1;
      rx_state_q    <= RX_HUNT;
      rx_cnt_q      <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_byte_q     <= '0;
      rx_good_q     <= 1'b0;
      rx_ferr_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      tx_byte_q     <= tx_byte_d;
      tx_bit_q      <= tx_bit_d;
      tx_cnt_q      <= tx_cnt_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      timer_q       <= timer_d;
      rx_count_q    <= rx_count_d;
      asm_q         <= asm_d;
      nonce_q       <= nonce_d;
      nonce_valid_q <= nonce_valid_d;
      done_q        <= done_d;
      rx_s1_q       <= rx_s1_d;
      rx_s2_q       <= rx_s2_d;
      rx_s3_q       <= rx_s3_d;
      rx_state_q    <= rx_state_d;
      rx_cnt_q      <= rx_cnt_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_byte_q     <= rx_byte_d;
      rx_good_q     <= rx_good_d;
      rx_ferr_q     <= rx_ferr_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign nonce       = nonce_q;
  assign nonce_valid = nonce_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_icarus_work_sender.sv
// tb_icarus_work_sender: directed bench for the work sender; expected TX bytes
// and nonces are queued when stimulus is applied and checked as they appear.
module tb_icarus_work_sender;

  localparam int DIV = 16;
  localparam int TMO = 2000;
  localparam int PKT = 640 * DIV;

  logic         clk      = 1'b0;
  logic         rst_n    = 1'b0;
  logic [255:0] midstate = '0;
  logic [255:0] data2    = '0;
  logic         start    = 1'b0;
  logic         rx       = 1'b1;
  logic         tx;
  logic         busy;
  logic [31:0]  nonce;
  logic         nonce_valid;
  logic         done;

  int total     = 0;
  int bad       = 0;
  int cyc       = 0;
  int acceptCyc = 0;
  int nvCount   = 0;
  int doneCount = 0;
  bit txMonOn   = 1'b0;

  logic [7:0]  txQ[$];
  logic [31:0] nonceQ[$];

  icarus_work_sender #(
    .CLOCK(16),
    .BAUD(1),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .midstate(midstate),
    .data2(data2),
    .start(start),
    .tx(tx),
    .rx(rx),
    .busy(busy),
    .nonce(nonce),
    .nonce_valid(nonce_valid),
    .done(done)
  );

  // Free-running clock and cycle counter used for latency checks
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " tx"}, tx, 1);
    checkOutput({tag, " busy"}, busy, 0);
    checkOutput({tag, " nonce"}, nonce, 0);
    checkOutput({tag, " nonce_valid"}, nonce_valid, 0);
    checkOutput({tag, " done"}, done, 0);
  endtask

  function automatic logic [511:0] makeWork(input logic [7:0] seed);
    logic [511:0] w;
    for (int i = 0; i < 64; i++) w[511-8*i -: 8] = seed + 8'(i * 29);
    return w;
  endfunction

  // Drive a one-cycle start with new work; optionally queue the bytes it should produce
  task automatic applyStimulus(input logic [511:0] work, input bit expectBytes);
    @(negedge clk);
    midstate = work[511:256];
    data2    = work[255:0];
    start    = 1'b1;
    if (expectBytes) begin
      for (int i = 0; i < 64; i++) txQ.push_back(work[511-8*i -: 8]);
    end
    @(negedge clk);
    start     = 1'b0;
    acceptCyc = cyc;
  endtask

  // Serialise one byte onto rx followed by two idle bit periods
  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stopBit;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic waitUntil(input int offset);
    while (cyc - acceptCyc < offset) @(negedge clk);
  endtask

  task automatic waitDone(input string tag, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    checkOutput(tag, done, 1);
  endtask

  // TX monitor: decode each frame at mid-bit and compare with the queued byte
  initial begin : txMonitor
    logic [7:0] got;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (txMonOn && tx === 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          got[i] = tx;
        end
        repeat (DIV) @(negedge clk);
        checkOutput("tx stop bit", tx, 1);
        exp = (txQ.size() > 0) ? txQ.pop_front() : 8'hxx;
        checkOutput("tx byte", {24'h0, got}, {24'h0, exp});
      end
    end
  end

  // Nonce monitor: every nonce_valid pulse must match the next queued nonce
  initial begin : nonceMonitor
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (nonce_valid === 1'b1) begin
        nvCount++;
        exp = (nonceQ.size() > 0) ? nonceQ.pop_front() : 32'hxxxxxxxx;
        checkOutput("nonce word", nonce, exp);
      end
      if (done === 1'b1) doneCount++;
    end
  end

  // Watchdog so the run always terminates
  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin : mainSeq
    logic [511:0] work;
    logic [9:0]   frame;
    int busyLow;
    int nvBase;
    int doneBase;

    rst_n = 1'b0;
    rx    = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkReset("reset");
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle tx", tx, 1);
    checkOutput("idle busy", busy, 0);

    // Packet A: exact framing of byte 0, busy across SEND, two nonces, done latency
    txMonOn = 1'b1;
    work    = makeWork(8'hA5);
    frame   = {1'b1, work[511:504], 1'b0};
    applyStimulus(work, 1'b1);
    busyLow = 0;
    for (int j = 0; j < PKT; j++) begin
      if (j < 10 * DIV) checkOutput("byte0 tx bit", tx, frame[j / DIV]);
      if (busy !== 1'b1) busyLow++;
      @(negedge clk);
    end
    checkOutput("busy through SEND", busyLow, 0);
    checkOutput("tx idle in WAIT", tx, 1);
    checkOutput("busy in WAIT", busy, 1);
    nvBase = nvCount;
    sendByte(8'h12, 1'b1);
    sendByte(8'h34, 1'b1);
    sendByte(8'h56, 1'b1);
    nonceQ.push_back(32'h12345678);
    sendByte(8'h78, 1'b1);
    sendByte(8'hDE, 1'b1);
    sendByte(8'hAD, 1'b1);
    sendByte(8'hBE, 1'b1);
    nonceQ.push_back(32'hDEADBEEF);
    sendByte(8'hEF, 1'b1);
    waitDone("done A", TMO);
    checkOutput("done A latency", cyc - acceptCyc, PKT + TMO);
    checkOutput("busy falls with done A", busy, 0);
    checkOutput("nonce count A", nvCount - nvBase, 2);
    checkOutput("nonce held A", nonce, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("done single cycle", done, 0);

    // Packet B: start at byte 10 ignored; framing error clears partial nonce
    work = makeWork(8'h3C);
    applyStimulus(work, 1'b1);
    waitUntil(10 * 10 * DIV + 5 * DIV);
    midstate = ~work[511:256];
    data2    = ~work[255:0];
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy after ignored start", busy, 1);
    waitUntil(PKT);
    nvBase = nvCount;
    sendByte(8'hAA, 1'b1);
    sendByte(8'hBB, 1'b1);
    sendByte(8'h55, 1'b0);
    sendByte(8'h01, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h03, 1'b1);
    nonceQ.push_back(32'h01020304);
    sendByte(8'h04, 1'b1);
    sendByte(8'h05, 1'b1);
    sendByte(8'h06, 1'b1);
    waitDone("done B", TMO);
    checkOutput("done B latency", cyc - acceptCyc, PKT + TMO);
    checkOutput("nonce count B", nvCount - nvBase, 1);
    checkOutput("nonce held B", nonce, 32'h01020304);

    // Packet C then restart from WAIT: no done, new start bit immediately
    work = makeWork(8'h71);
    applyStimulus(work, 1'b1);
    waitUntil(PKT + TMO - 100);
    checkOutput("C bytes all decoded", txQ.size(), 0);
    doneBase = doneCount;
    txMonOn  = 1'b0;
    applyStimulus(makeWork(8'h0F), 1'b0);
    checkOutput("restart tx start bit", tx, 0);
    checkOutput("restart busy", busy, 1);
    waitUntil(2 * 10 * DIV + 5 * DIV);
    checkOutput("no done on abort", doneCount - doneBase, 0);
    checkOutput("busy before reset", busy, 1);

    // Reset in the middle of byte 2, then a full packet from byte 0
    rst_n = 1'b0;
    @(negedge clk);
    checkReset("mid-byte reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txMonOn = 1'b1;
    work    = makeWork(8'hC3);
    applyStimulus(work, 1'b1);
    checkOutput("E tx start bit", tx, 0);
    checkOutput("E busy", busy, 1);
    waitUntil(PKT);
    checkOutput("E bytes all decoded", txQ.size(), 0);
    waitDone("done E", TMO + 10);
    checkOutput("done E latency", cyc - acceptCyc, PKT + TMO);
    checkOutput("nonce queue drained", nonceQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
